instr_issue_queue: RTL and testbench
====================================

# instr_issue_queue

Instruction buffer and issue sequencer that sits directly upstream of the systolic `top` and drives its `i_Instr_In` port. It accepts instruction words from the host side into a FIFO and issues them one per cycle. It stalls after an `EX` until `top` raises its finish flag. It stalls after a `WBPSRAM` until the write-back burst from `top` has ended.

## Interface
- `BIT_INSTR`, 32: instruction width.
  - Bit [31] is OPVALID.
  - Bits [30:28] are the opcode.
  - Bits [27:0] are the payload.
- `DEPTH`, 128: FIFO entries; must be a power of two.
- `OPC_EX`, 3'd1: opcode value that triggers the wait-for-finish stall.
- `OPC_WB`, 3'd2: opcode value that triggers the wait-for-write-back stall.
- `CLK` input 1: single clock; all state changes on the rising edge.
- `RSTb` input 1: asynchronous, active-low reset.
- `i_Wr_En` input 1: host push strobe.
- `i_Wr_Instr` input BIT_INSTR: instruction word to push.
- `i_Start` input 1: level-sensitive issue enable.
- `i_Flag_Finish` input 1: from `top` `o_Flag_Finish_Out`.
- `i_Valid_WB` input 1: from `top` `o_Valid_WB_Out`.
- `o_Instr_Out` output BIT_INSTR: to `top` `i_Instr_In`; registered.
- `o_Full` output 1: FIFO holds DEPTH entries.
- `o_Empty` output 1: FIFO holds 0 entries.
- `o_Count` output log2(DEPTH)+1: occupancy.
- `o_Overflow` output 1: sticky; set when a push is dropped.
- `o_Busy` output 1: the FSM is in a state other than IDLE.

## Operation
- The FIFO uses circular read and write pointers with log2(DEPTH) bits; both wrap from DEPTH-1 to 0.
  - `o_Count` increments on a push, decrements on a pop, and is unchanged when both happen in the same cycle.
- Push rule: `i_Wr_En` with `o_Full` low stores the word.
  - `i_Wr_En` with `o_Full` high drops the word and sets `o_Overflow`, even if a pop occurs in the same cycle.
  - Only reset clears `o_Overflow`.
- Words with OPVALID=0 are stored and issued like any other word. They never stall the FSM.
- FSM states:
  - IDLE
    - Goes to ISSUE when `i_Start`=1.
    - Drives zero.
  - ISSUE
    - Each cycle with FIFO not empty: pop one word and register it onto `o_Instr_Out`.
    - Each cycle with FIFO empty: drive zero.
    - If the popped word has OPVALID=1 and opcode OPC_EX, go to WAIT_EX.
    - If the popped word has OPVALID=1 and opcode OPC_WB, go to WAIT_WB.
    - If `i_Start`=0 and no pop occurs this cycle, go to IDLE.
  - WAIT_EX
    - Drives zero.
    - Goes back to ISSUE on the first cycle with `i_Flag_Finish`=1.
  - WAIT_WB
    - Drives zero.
    - Uses an internal `seen` bit, cleared on entry and set when `i_Valid_WB`=1.
    - Goes back to ISSUE on the first cycle with `seen`=1 and `i_Valid_WB`=0, i.e. the falling edge of the burst.
- `i_Start` deasserting in WAIT_EX or WAIT_WB does not abort the wait. The FSM goes to IDLE once the wait completes.
- `i_Flag_Finish` and `i_Valid_WB` are ignored outside their respective wait states.
- Pushes are accepted in every state.

## Timing
- All outputs reset to zero:
  - `o_Instr_Out`=0, `o_Full`=0, `o_Empty`=1, `o_Count`=0, `o_Overflow`=0, `o_Busy`=0.
  - The FSM resets to IDLE and the FIFO is flushed.
- Latency:
  - A word pushed at edge t can be popped at edge t+1 at the earliest, so it appears on `o_Instr_Out` after edge t+1.
  - There is no write-to-read bypass.
- Throughput: one instruction per cycle while in ISSUE with FIFO not empty.
- `o_Instr_Out` holds each issued word for exactly one cycle, then returns to zero unless the next word is issued.
- After the EX word is presented at edge t, `i_Flag_Finish`=1 sampled at edge t+k gives:
  - the transition WAIT_EX→ISSUE at edge t+k;
  - the next word on `o_Instr_Out` after edge t+k+1.
- An empty→ISSUE stall emits zeros and does not change state.
- Reset mid-operation immediately zeroes all outputs and discards the FIFO contents.

## Test plan
- Reset with `i_Start`=0, push 5 words → `o_Count`=5, `o_Empty`=0, `o_Instr_Out` stays 0, `o_Busy`=0.
- Push 3 LDSRAM words, then raise `i_Start` → the words appear on `o_Instr_Out` in 3 consecutive cycles, followed by zeros; `o_Count` ends at 0.
- Queue LDSRAM, EX, LDSRAM, start; pulse `i_Flag_Finish` 10 cycles after EX issues → the second LDSRAM issues exactly 2 cycles after the pulse edge and not before.
- Queue WBPSRAM then LDSRAM; drive `i_Valid_WB` high for 4 cycles starting 3 cycles after issue → LDSRAM issues 2 cycles after `i_Valid_WB` falls.
- Push 129 words with DEPTH=128 while stopped → `o_Full`=1, `o_Overflow`=1, word 129 is never issued; drain to confirm words 0–127 come out in order, across pointer wrap.
- Assert `RSTb`=0 while in WAIT_EX with 4 words queued → `o_Count`=0, `o_Busy`=0, `o_Instr_Out`=0, and nothing issues after release until a new push plus `i_Start`.

Source files
------------

// File: rtl/instr_issue_queue.sv
// ============================================================================
// Module      : instr_issue_queue
// Description : Instruction FIFO and issue sequencer feeding the systolic
//               array; stalls after EX until finish and after WBPSRAM until
//               the write-back burst ends.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_issue_queue #(
    parameter int         BIT_INSTR = 32,
    parameter int         DEPTH     = 128,
    parameter logic [2:0] OPC_EX    = 3'd1,
    parameter logic [2:0] OPC_WB    = 3'd2
) (
    input  logic                       CLK,
    input  logic                       RSTb,
    input  logic                       i_Wr_En,
    input  logic [BIT_INSTR-1:0]       i_Wr_Instr,
    input  logic                       i_Start,
    input  logic                       i_Flag_Finish,
    input  logic                       i_Valid_WB,
    output logic [BIT_INSTR-1:0]       o_Instr_Out,
    output logic                       o_Full,
    output logic                       o_Empty,
    output logic [$clog2(DEPTH):0]     o_Count,
    output logic                       o_Overflow,
    output logic                       o_Busy
);

    localparam int                c_AW        = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_DEPTH_CNT = (c_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_EX = 2'd2,
        S_WAIT_WB = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [BIT_INSTR-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]        r_wr_ptr;
    logic [c_AW-1:0]        r_rd_ptr;
    logic [c_AW:0]          r_count;
    logic                   r_overflow;
    logic                   r_seen;
    logic [BIT_INSTR-1:0]   r_instr_out;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic [BIT_INSTR-1:0]   w_head;
    logic                   w_head_ex;
    logic                   w_head_wb;

    assign w_full  = (r_count == c_DEPTH_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = i_Wr_En && !w_full;
    assign w_pop   = (r_state == S_ISSUE) && !w_empty;
    assign w_head  = r_mem[r_rd_ptr];

    // Only words with OPVALID set may stall the sequencer.
    assign w_head_ex = w_head[BIT_INSTR-1] && (w_head[BIT_INSTR-2 -: 3] == OPC_EX);
    assign w_head_wb = w_head[BIT_INSTR-1] && (w_head[BIT_INSTR-2 -: 3] == OPC_WB);

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_Wr_Instr;
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A push against a full FIFO is lost even if a pop frees a slot.
            if (i_Wr_En && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_state     <= S_IDLE;
            r_seen      <= 1'b0;
            r_instr_out <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_instr_out <= w_pop ? w_head : '0;
            if (r_state != S_WAIT_WB) begin
                r_seen <= 1'b0;
            end else if (i_Valid_WB) begin
                r_seen <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_Start) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_pop && w_head_ex) begin
                    w_state_nxt = S_WAIT_EX;
                end else if (w_pop && w_head_wb) begin
                    w_state_nxt = S_WAIT_WB;
                end else if (!i_Start && !w_pop) begin
                    w_state_nxt = S_IDLE;
                end
            end
            // A start dropped during a wait takes effect once the wait ends.
            S_WAIT_EX: begin
                if (i_Flag_Finish) begin
                    w_state_nxt = i_Start ? S_ISSUE : S_IDLE;
                end
            end
            S_WAIT_WB: begin
                if (r_seen && !i_Valid_WB) begin
                    w_state_nxt = i_Start ? S_ISSUE : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_Instr_Out = r_instr_out;
    assign o_Full      = w_full;
    assign o_Empty     = w_empty;
    assign o_Count     = r_count;
    assign o_Overflow  = r_overflow;
    assign o_Busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_instr_issue_queue.sv
// ============================================================================
// Module      : tb_instr_issue_queue
// Description : Directed self-checking bench for instr_issue_queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_issue_queue;

    logic        CLK;
    logic        RSTb;
    logic        i_Wr_En;
    logic [31:0] i_Wr_Instr;
    logic        i_Start;
    logic        i_Flag_Finish;
    logic        i_Valid_WB;
    logic [31:0] o_Instr_Out;
    logic        o_Full;
    logic        o_Empty;
    logic [7:0]  o_Count;
    logic        o_Overflow;
    logic        o_Busy;

    int n_cmp = 0;
    int n_err = 0;

    instr_issue_queue #(
        .BIT_INSTR (32),
        .DEPTH     (128),
        .OPC_EX    (3'd1),
        .OPC_WB    (3'd2)
    ) dut (
        .CLK           (CLK),
        .RSTb          (RSTb),
        .i_Wr_En       (i_Wr_En),
        .i_Wr_Instr    (i_Wr_Instr),
        .i_Start       (i_Start),
        .i_Flag_Finish (i_Flag_Finish),
        .i_Valid_WB    (i_Valid_WB),
        .o_Instr_Out   (o_Instr_Out),
        .o_Full        (o_Full),
        .o_Empty       (o_Empty),
        .o_Count       (o_Count),
        .o_Overflow    (o_Overflow),
        .o_Busy        (o_Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mk(input logic [2:0] op, input int p);
        logic [31:0] v;
        v = p;
        return {1'b1, op, v[27:0]};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RSTb = 1'b0; i_Wr_En = 1'b0; i_Wr_Instr = '0; i_Start = 1'b0;
        i_Flag_Finish = 1'b0; i_Valid_WB = 1'b0;
        tick(); tick();
        RSTb = 1'b1;
    endtask

    task automatic push(input logic [31:0] w);
        i_Wr_En = 1'b1; i_Wr_Instr = w;
        tick();
        i_Wr_En = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (o_Instr_Out !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h expected %h", o_Instr_Out, 32'h0); end
        n_cmp++; if (o_Empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b expected 1", o_Empty); end
        n_cmp++; if (o_Full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b expected 0", o_Full); end
        n_cmp++; if (o_Count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", o_Count); end
        n_cmp++; if (o_Overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", o_Overflow); end
        n_cmp++; if (o_Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", o_Busy); end
    endtask

    task automatic test_push_stopped();
        do_reset();
        for (int i = 0; i < 5; i++) push(mk(3'd3, i));
        tick();
        n_cmp++; if (o_Count !== 8'd5) begin n_err++; $display("FAIL stopped_count: got %0d expected 5", o_Count); end
        n_cmp++; if (o_Empty !== 1'b0) begin n_err++; $display("FAIL stopped_empty: got %b expected 0", o_Empty); end
        n_cmp++; if (o_Instr_Out !== 32'h0) begin n_err++; $display("FAIL stopped_instr: got %h expected 0", o_Instr_Out); end
        n_cmp++; if (o_Busy !== 1'b0) begin n_err++; $display("FAIL stopped_busy: got %b expected 0", o_Busy); end
    endtask

    task automatic test_basic_issue();
        logic [31:0] exp_q [6];
        do_reset();
        for (int i = 0; i < 3; i++) push(mk(3'd3, 16'h100 + i));
        exp_q[0] = 32'h0;
        exp_q[1] = mk(3'd3, 16'h100);
        exp_q[2] = mk(3'd3, 16'h101);
        exp_q[3] = mk(3'd3, 16'h102);
        exp_q[4] = 32'h0;
        exp_q[5] = 32'h0;
        i_Start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if (o_Instr_Out !== exp_q[i]) begin n_err++; $display("FAIL basic_out[%0d]: got %h expected %h", i, o_Instr_Out, exp_q[i]); end
        end
        n_cmp++; if (o_Count !== 8'd0) begin n_err++; $display("FAIL basic_count: got %0d expected 0", o_Count); end
        n_cmp++; if (o_Busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b expected 1", o_Busy); end
        i_Start = 1'b0;
        tick();
        n_cmp++; if (o_Busy !== 1'b0) begin n_err++; $display("FAIL basic_idle: got %b expected 0", o_Busy); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push(mk(3'd3, 1));
        push(mk(3'd3, 2));
        i_Start = 1'b1; i_Wr_En = 1'b1; i_Wr_Instr = mk(3'd3, 3);
        tick();
        n_cmp++; if (o_Count !== 8'd3) begin n_err++; $display("FAIL b2b_count0: got %0d expected 3", o_Count); end
        i_Wr_Instr = mk(3'd3, 4);
        tick();
        i_Wr_En = 1'b0;
        n_cmp++; if (o_Instr_Out !== mk(3'd3, 1)) begin n_err++; $display("FAIL b2b_out0: got %h expected %h", o_Instr_Out, mk(3'd3, 1)); end
        n_cmp++; if (o_Count !== 8'd3) begin n_err++; $display("FAIL b2b_count_pushpop: got %0d expected 3", o_Count); end
        for (int i = 2; i <= 4; i++) begin
            tick();
            n_cmp++; if (o_Instr_Out !== mk(3'd3, i)) begin n_err++; $display("FAIL b2b_out%0d: got %h expected %h", i, o_Instr_Out, mk(3'd3, i)); end
        end
        tick();
        n_cmp++; if (o_Instr_Out !== 32'h0) begin n_err++; $display("FAIL b2b_tail: got %h expected 0", o_Instr_Out); end
        i_Start = 1'b0;
    endtask

    task automatic test_ex_stall();
        do_reset();
        push(mk(3'd3, 16'hA0));
        push(mk(3'd1, 16'hE0));
        push(mk(3'd3, 16'hA1));
        i_Start = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (o_Instr_Out !== mk(3'd1, 16'hE0)) begin n_err++; $display("FAIL ex_word: got %h expected %h", o_Instr_Out, mk(3'd1, 16'hE0)); end
        for (int i = 0; i < 9; i++) begin
            tick();
            n_cmp++; if (o_Instr_Out !== 32'h0) begin n_err++; $display("FAIL ex_stall[%0d]: got %h expected 0", i, o_Instr_Out); end
        end
        n_cmp++; if (o_Count !== 8'd1) begin n_err++; $display("FAIL ex_count: got %0d expected 1", o_Count); end
        i_Flag_Finish = 1'b1;
        tick();
        i_Flag_Finish = 1'b0;
        n_cmp++; if (o_Instr_Out !== 32'h0) begin n_err++; $display("FAIL ex_pulse_edge: got %h expected 0", o_Instr_Out); end
        tick();
        n_cmp++; if (o_Instr_Out !== mk(3'd3, 16'hA1)) begin n_err++; $display("FAIL ex_resume: got %h expected %h", o_Instr_Out, mk(3'd3, 16'hA1)); end
        tick();
        n_cmp++; if (o_Instr_Out !== 32'h0) begin n_err++; $display("FAIL ex_after: got %h expected 0", o_Instr_Out); end
        i_Start = 1'b0;
    endtask

    task automatic test_wb_stall();
        do_reset();
        push(mk(3'd2, 16'hB0));
        push(mk(3'd3, 16'hB1));
        i_Start = 1'b1;
        tick(); tick();
        n_cmp++; if (o_Instr_Out !== mk(3'd2, 16'hB0)) begin n_err++; $display("FAIL wb_word: got %h expected %h", o_Instr_Out, mk(3'd2, 16'hB0)); end
        // Finish flag must be ignored while waiting for write-back.
        i_Flag_Finish = 1'b1;
        tick(); tick();
        i_Valid_WB = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (o_Instr_Out !== 32'h0) begin n_err++; $display("FAIL wb_burst[%0d]: got %h expected 0", i, o_Instr_Out); end
        end
        i_Valid_WB = 1'b0;
        tick();
        n_cmp++; if (o_Instr_Out !== 32'h0) begin n_err++; $display("FAIL wb_fall: got %h expected 0", o_Instr_Out); end
        tick();
        n_cmp++; if (o_Instr_Out !== mk(3'd3, 16'hB1)) begin n_err++; $display("FAIL wb_resume: got %h expected %h", o_Instr_Out, mk(3'd3, 16'hB1)); end
        i_Flag_Finish = 1'b0;
        i_Start = 1'b0;
    endtask

    task automatic test_overflow_wrap();
        do_reset();
        for (int i = 0; i < 128; i++) push(mk(3'd3, i));
        n_cmp++; if (o_Full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b expected 1", o_Full); end
        n_cmp++; if (o_Overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b expected 0", o_Overflow); end
        push(mk(3'd3, 128));
        n_cmp++; if (o_Overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", o_Overflow); end
        n_cmp++; if (o_Count !== 8'd128) begin n_err++; $display("FAIL ovf_count: got %0d expected 128", o_Count); end
        i_Start = 1'b1;
        tick();
        for (int i = 0; i < 128; i++) begin
            tick();
            n_cmp++; if (o_Instr_Out !== mk(3'd3, i)) begin n_err++; $display("FAIL drain[%0d]: got %h expected %h", i, o_Instr_Out, mk(3'd3, i)); end
        end
        tick();
        n_cmp++; if (o_Instr_Out !== 32'h0) begin n_err++; $display("FAIL drain_tail: got %h expected 0", o_Instr_Out); end
        n_cmp++; if (o_Empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b expected 1", o_Empty); end
        n_cmp++; if (o_Overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", o_Overflow); end
        i_Start = 1'b0;
        tick();
    endtask

    task automatic test_reset_midwait();
        do_reset();
        push(mk(3'd3, 16'hC0));
        push(mk(3'd1, 16'hC1));
        for (int i = 0; i < 4; i++) push(mk(3'd3, 16'hC2 + i));
        i_Start = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (o_Count !== 8'd4) begin n_err++; $display("FAIL mid_count: got %0d expected 4", o_Count); end
        n_cmp++; if (o_Busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b expected 1", o_Busy); end
        #2;
        RSTb = 1'b0; i_Start = 1'b0;
        #1;
        n_cmp++; if (o_Count !== 8'd0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", o_Count); end
        n_cmp++; if (o_Busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", o_Busy); end
        n_cmp++; if (o_Instr_Out !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h expected 0", o_Instr_Out); end
        tick();
        RSTb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (o_Instr_Out !== 32'h0) begin n_err++; $display("FAIL post_rst[%0d]: got %h expected 0", i, o_Instr_Out); end
        end
        push(mk(3'd3, 16'hD0));
        tick();
        n_cmp++; if (o_Instr_Out !== 32'h0) begin n_err++; $display("FAIL post_push_nostart: got %h expected 0", o_Instr_Out); end
        i_Start = 1'b1;
        tick(); tick();
        n_cmp++; if (o_Instr_Out !== mk(3'd3, 16'hD0)) begin n_err++; $display("FAIL post_rst_issue: got %h expected %h", o_Instr_Out, mk(3'd3, 16'hD0)); end
        i_Start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_push_stopped();
        test_basic_issue();
        test_back_to_back();
        test_ex_stall();
        test_wb_stall();
        test_overflow_wrap();
        test_reset_midwait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
